can_bus_sched: RTL and testbench

Bus-state controller that sequences `can_timing` and the bit stream processor. It tracks the node's view of the bus: integration after reset or bus-off, idle, receiving, transmitting, intermission and suspend-transmission. From that view it drives `rx_idle`, `rx_inter`, `go_tx`, `transmitting` and `transmitter` into the timing block. It advances only on `sample_point` events and on pulses from the bit stream processor.

---
 rtl/can_bus_sched_pkg.sv | 31 +++
 rtl/can_bus_sched_if.sv | 35 +++
 rtl/can_recessive_cnt.sv | 45 ++++
 rtl/can_bus_sched.sv | 157 +++++++++++++++
 tb/tb_can_bus_sched.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/can_bus_sched_pkg.sv
// Shared types and bit-count constants for the CAN bus-state scheduler.
package can_bus_sched_pkg;

  typedef enum logic [2:0] {
    S_INTEG   = 3'd0,
    S_IDLE    = 3'd1,
    S_RX      = 3'd2,
    S_TX      = 3'd3,
    S_INTER   = 3'd4,
    S_SUSPEND = 3'd5
  } type_sched_state_e;

  localparam logic [3:0] CAN_INTEG_BITS   = 4'd11;
  localparam logic [3:0] CAN_INTER_BITS   = 4'd3;
  localparam logic [3:0] CAN_SUSPEND_BITS = 4'd8;
  localparam logic [3:0] CAN_CNT_MAX      = 4'd11;

  // Recessive-bit target for the counting states; non-counting states return 0.
  function automatic logic [3:0] cnt_target(input type_sched_state_e st);
    logic [3:0] tgt;
    tgt = 4'd0;
    case (st)
      S_INTEG:   tgt = CAN_INTEG_BITS;
      S_INTER:   tgt = CAN_INTER_BITS;
      S_SUSPEND: tgt = CAN_SUSPEND_BITS;
      default:   tgt = 4'd0;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/can_bus_sched_if.sv
// Strobes from can_timing / bit stream processor and the scheduler's bus-state outputs.
interface can_bus_sched_if;

  logic sample_point;
  logic sampled_bit;
  logic hard_sync;
  logic tx_request;
  logic arb_lost;
  logic frame_end;
  logic node_error_passive;
  logic node_bus_off;

  logic rx_idle;
  logic rx_inter;
  logic go_tx;
  logic transmitting;
  logic transmitter;
  logic overload_req;
  logic bus_on;

  modport master (
    input  sample_point, sampled_bit, hard_sync, tx_request,
           arb_lost, frame_end, node_error_passive, node_bus_off,
    output rx_idle, rx_inter, go_tx, transmitting, transmitter,
           overload_req, bus_on
  );

  modport slave (
    output sample_point, sampled_bit, hard_sync, tx_request,
           arb_lost, frame_end, node_error_passive, node_bus_off,
    input  rx_idle, rx_inter, go_tx, transmitting, transmitter,
           overload_req, bus_on
  );

endinterface

// File: rtl/can_recessive_cnt.sv
// Saturating count of consecutive recessive sample points, with a last-bit compare
// so the FSM can leave a state on the same edge that samples the final bit.
module can_recessive_cnt
  import can_bus_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       cnt_en,
  input  logic       sample_point,
  input  logic       sampled_bit,
  input  logic [3:0] target,
  output logic [3:0] cnt,
  output logic       at_last
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (cnt_en && sample_point) begin
      if (!sampled_bit) begin
        cnt_d = 4'd0;
      end else if (cnt_q < CAN_CNT_MAX) begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  // True when one more recessive sample completes the target run.
  assign at_last = ({1'b0, cnt_q} + 5'd1) >= {1'b0, target};

endmodule

// File: rtl/can_bus_sched.sv
// CAN bus-state controller: tracks integration, idle, rx/tx, intermission and
// suspend, and drives the timing block's bus-state inputs.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_INTEG   | waiting for 11 recessive bits after reset / bus-off
// S_IDLE    | bus idle, may start a frame
// S_RX      | receiving a frame (or lost arbitration)
// S_TX      | transmitting a frame
// S_INTER   | 3-bit intermission
// S_SUSPEND | 8-bit suspend-transmission of an error-passive transmitter
module can_bus_sched
  import can_bus_sched_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  can_bus_sched_if.master  bus
);

  type_sched_state_e state_q, state_d;

  logic       go_tx_q, go_tx_d;
  logic       overload_req_q, overload_req_d;
  logic       transmitter_q, transmitter_d;
  logic       rx_idle_q, rx_idle_d;
  logic       rx_inter_q, rx_inter_d;
  logic       transmitting_q, transmitting_d;
  logic       bus_on_q, bus_on_d;

  logic       cnt_clr;
  logic       cnt_en;
  logic [3:0] cnt;
  logic       at_last;
  logic       rec_sp;
  logic       dom_sp;

  assign rec_sp  = bus.sample_point &&  bus.sampled_bit;
  assign dom_sp  = bus.sample_point && !bus.sampled_bit;
  assign cnt_en  = (state_q == S_INTEG) || (state_q == S_INTER) || (state_q == S_SUSPEND);
  assign cnt_clr = (state_d != state_q) || bus.node_bus_off;

  can_recessive_cnt u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (cnt_clr),
    .cnt_en       (cnt_en),
    .sample_point (bus.sample_point),
    .sampled_bit  (bus.sampled_bit),
    .target       (cnt_target(state_q)),
    .cnt          (cnt),
    .at_last      (at_last)
  );

  always_comb begin
    state_d        = state_q;
    go_tx_d        = 1'b0;
    overload_req_d = 1'b0;
    transmitter_d  = transmitter_q;

    if (bus.node_bus_off) begin
      state_d = S_INTEG;
    end else if (bus.arb_lost && (state_q == S_TX)) begin
      state_d = S_RX;
    end else if (bus.frame_end && ((state_q == S_TX) || (state_q == S_RX))) begin
      state_d = S_INTER;
    end else begin
      case (state_q)
        S_INTEG: begin
          if (rec_sp && at_last) state_d = S_IDLE;
        end
        S_IDLE: begin
          // A pending frame wins over a foreign SOF so the node joins arbitration.
          if (bus.tx_request) begin
            go_tx_d = 1'b1;
            state_d = S_TX;
          end else if (bus.hard_sync) begin
            state_d = S_RX;
          end
        end
        S_INTER: begin
          if (dom_sp) begin
            if (cnt < 4'd2) begin
              overload_req_d = 1'b1;
              state_d        = S_RX;
            end else if (bus.tx_request) begin
              go_tx_d = 1'b1;
              state_d = S_TX;
            end else begin
              state_d = S_RX;
            end
          end else if (rec_sp && at_last) begin
            if (transmitter_q && bus.node_error_passive) begin
              state_d = S_SUSPEND;
            end else if (bus.tx_request) begin
              go_tx_d = 1'b1;
              state_d = S_TX;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_SUSPEND: begin
          if (dom_sp) begin
            state_d = S_RX;
          end else if (rec_sp && at_last) begin
            state_d = S_IDLE;
          end
        end
        default: ;
      endcase
    end

    if (bus.node_bus_off) begin
      transmitter_d = 1'b0;
    end else if (go_tx_d) begin
      transmitter_d = 1'b1;
    end else if ((state_d != state_q) && ((state_d == S_RX) || (state_d == S_IDLE))) begin
      transmitter_d = 1'b0;
    end

    rx_idle_d      = (state_d == S_IDLE);
    rx_inter_d     = (state_d == S_INTER);
    transmitting_d = (state_d == S_TX);
    bus_on_d       = (state_d != S_INTEG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_INTEG;
      go_tx_q        <= 1'b0;
      overload_req_q <= 1'b0;
      transmitter_q  <= 1'b0;
      rx_idle_q      <= 1'b0;
      rx_inter_q     <= 1'b0;
      transmitting_q <= 1'b0;
      bus_on_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      go_tx_q        <= go_tx_d;
      overload_req_q <= overload_req_d;
      transmitter_q  <= transmitter_d;
      rx_idle_q      <= rx_idle_d;
      rx_inter_q     <= rx_inter_d;
      transmitting_q <= transmitting_d;
      bus_on_q       <= bus_on_d;
    end
  end

  assign bus.rx_idle      = rx_idle_q;
  assign bus.rx_inter     = rx_inter_q;
  assign bus.go_tx        = go_tx_q;
  assign bus.transmitting = transmitting_q;
  assign bus.transmitter  = transmitter_q;
  assign bus.overload_req = overload_req_q;
  assign bus.bus_on       = bus_on_q;

endmodule

// File: tb/tb_can_bus_sched.sv
// Directed bench for can_bus_sched: expected output vectors are queued with the
// stimulus and compared one cycle later.
module tb_can_bus_sched;

  logic clk;
  logic rst_n;

  can_bus_sched_if bus_if ();

  can_bus_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {rx_idle, rx_inter, go_tx, transmitting, transmitter, overload_req, bus_on}
  localparam logic [6:0] O_INTEG   = 7'b0000000;
  localparam logic [6:0] O_IDLE    = 7'b1000001;
  localparam logic [6:0] O_GO      = 7'b0011101;
  localparam logic [6:0] O_TX      = 7'b0001101;
  localparam logic [6:0] O_RX      = 7'b0000001;
  localparam logic [6:0] O_INTER_T = 7'b0100101;
  localparam logic [6:0] O_INTER_R = 7'b0100001;
  localparam logic [6:0] O_OVL     = 7'b0000011;
  localparam logic [6:0] O_SUSP    = 7'b0000101;

  logic [6:0] outs;
  assign outs = {bus_if.rx_idle, bus_if.rx_inter, bus_if.go_tx, bus_if.transmitting,
                 bus_if.transmitter, bus_if.overload_req, bus_if.bus_on};

  typedef struct {
    string      tag;
    logic [6:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic expect_out(input string tag, input logic [6:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, outs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
    bus_if.sample_point = 1'b0;
    bus_if.sampled_bit  = 1'b1;
    bus_if.hard_sync    = 1'b0;
    bus_if.arb_lost     = 1'b0;
    bus_if.frame_end    = 1'b0;
  endtask

  task automatic rec(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.sample_point = 1'b1;
      bus_if.sampled_bit  = 1'b1;
      tick();
    end
  endtask

  task automatic dom();
    bus_if.sample_point = 1'b1;
    bus_if.sampled_bit  = 1'b0;
    tick();
  endtask

  initial begin
    bus_if.sample_point       = 1'b0;
    bus_if.sampled_bit        = 1'b1;
    bus_if.hard_sync          = 1'b0;
    bus_if.tx_request         = 1'b0;
    bus_if.arb_lost           = 1'b0;
    bus_if.frame_end          = 1'b0;
    bus_if.node_error_passive = 1'b0;
    bus_if.node_bus_off       = 1'b0;
    rst_n = 1'b0;
    #12;
    expect_out("reset", O_INTEG);
    drain();
    rst_n = 1'b1;

    // Integration, hard_sync ignored, dominant at 7th sample restarts the run
    bus_if.hard_sync = 1'b1;
    expect_out("integ_hsync", O_INTEG);
    tick();
    rec(6);
    dom();
    rec(9);
    expect_out("integ_10", O_INTEG);
    rec(1);
    expect_out("integ_done", O_IDLE);
    rec(1);

    // Idle TX, frame end, intermission back to idle
    bus_if.tx_request = 1'b1;
    expect_out("idle_go", O_GO);
    tick();
    bus_if.tx_request = 1'b0;
    expect_out("tx_hold", O_TX);
    tick();
    bus_if.frame_end = 1'b1;
    expect_out("tx_fe", O_INTER_T);
    tick();
    rec(1);
    expect_out("inter_2", O_INTER_T);
    rec(1);
    expect_out("inter_idle", O_IDLE);
    rec(1);

    // Simultaneous SOF and tx_request
    bus_if.hard_sync  = 1'b1;
    bus_if.tx_request = 1'b1;
    expect_out("sof_go", O_GO);
    tick();
    expect_out("sof_tx", O_TX);
    tick();

    // Arbitration loss, then frame end as receiver
    bus_if.tx_request = 1'b0;
    bus_if.arb_lost   = 1'b1;
    expect_out("arb_lost", O_RX);
    tick();
    bus_if.frame_end = 1'b1;
    expect_out("rx_fe", O_INTER_R);
    tick();

    // Overload: dominant at intermission bit 2
    expect_out("ovl_bit1", O_INTER_R);
    rec(1);
    expect_out("ovl_pulse", O_OVL);
    dom();
    expect_out("ovl_end", O_RX);
    tick();
    bus_if.frame_end = 1'b1;
    expect_out("ovl_fe", O_INTER_R);
    tick();
    rec(2);
    expect_out("ovl_idle", O_IDLE);
    rec(1);

    // Error-passive transmitter: 3 + 8 recessive before idle
    bus_if.node_error_passive = 1'b1;
    bus_if.tx_request         = 1'b1;
    expect_out("ep_go", O_GO);
    tick();
    bus_if.tx_request = 1'b0;
    bus_if.frame_end  = 1'b1;
    expect_out("ep_fe", O_INTER_T);
    tick();
    rec(2);
    expect_out("ep_susp", O_SUSP);
    rec(1);
    rec(6);
    expect_out("ep_susp_7", O_SUSP);
    rec(1);
    expect_out("ep_idle", O_IDLE);
    rec(1);

    // Dominant at suspend bit 4
    bus_if.tx_request = 1'b1;
    expect_out("sd_go", O_GO);
    tick();
    bus_if.tx_request = 1'b0;
    bus_if.frame_end  = 1'b1;
    tick();
    rec(3);
    rec(3);
    expect_out("sd_susp_3", O_SUSP);
    tick();
    expect_out("sd_rx", O_RX);
    dom();
    bus_if.node_error_passive = 1'b0;

    // Dominant at intermission bit 3 with a pending frame: SOF as transmitter
    bus_if.frame_end = 1'b1;
    tick();
    rec(2);
    bus_if.tx_request = 1'b1;
    expect_out("inter3_go", O_GO);
    dom();
    bus_if.tx_request = 1'b0;

    // Bus-off in TX, then fresh integration
    bus_if.node_bus_off = 1'b1;
    expect_out("busoff", O_INTEG);
    tick();
    expect_out("busoff_hold", O_INTEG);
    rec(12);
    bus_if.node_bus_off = 1'b0;
    rec(9);
    expect_out("reint_10", O_INTEG);
    rec(1);
    expect_out("reint_done", O_IDLE);
    rec(1);

    // arb_lost beats frame_end
    bus_if.tx_request = 1'b1;
    tick();
    bus_if.tx_request = 1'b0;
    bus_if.arb_lost   = 1'b1;
    bus_if.frame_end  = 1'b1;
    expect_out("prio_arb", O_RX);
    tick();

    // Async reset mid-TX
    bus_if.frame_end = 1'b1;
    tick();
    bus_if.tx_request = 1'b1;
    rec(2);
    expect_out("pre_rst_go", O_GO);
    rec(1);
    expect_out("pre_rst_tx", O_TX);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("rst_async", O_INTEG);
    drain();
    #2;
    rst_n = 1'b1;
    expect_out("rst_release", O_INTEG);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
